apb_master_arb: RTL and testbench
=================================

APB_MASTER_ARB -- requirements
Module: apb_master_arb

Interface
REQ-001 The parameter ADDR_W SHALL default to 4 and set the APB address width.
REQ-002 The parameter DATA_W SHALL default to 8 and set the APB data width.
REQ-003 The parameter TIMEOUT_CYCLES SHALL default to 15 and set the maximum wait cycles allowed in ACCESS (used only with the timeout feature).
REQ-004 pclk  input  1  the only clock; all state updates on its rising edge.
REQ-005 presetn  input  1  asynchronous active-low reset.
REQ-006 req_i  input  2  per-requester transfer request, held high until that requester's done_o.
REQ-007 write_i  input  2  per-requester direction: 1 = write, 0 = read.
REQ-008 addr_i  input  2*ADDR_W  per-requester address; requester n uses slice [n*ADDR_W +: ADDR_W].
REQ-009 wdata_i  input  2*DATA_W  per-requester write data; requester n uses slice [n*DATA_W +: DATA_W].
REQ-010 done_o  output  2  one-cycle completion pulse per requester.
REQ-011 err_o  output  2  error flag, valid only with the matching done_o bit.
REQ-012 rdata_o  output  DATA_W  read data, valid with done_o.
REQ-013 busy_o  output  1  high in SETUP and ACCESS.
REQ-014 psel, penable, pwrite  output  1 each  APB master controls.
REQ-015 paddr  output  ADDR_W  APB address; pwdata  output  DATA_W  APB write data.
REQ-016 prdata  input  DATA_W  APB read data; pready  input  1  APB slave ready / wait control.

Function
REQ-017 The FSM SHALL have three states: IDLE, SETUP and ACCESS.
REQ-018 IDLE SHALL go to SETUP on the next edge if any req_i bit is high; otherwise it SHALL stay in IDLE.
REQ-019 IDLE arbitration SHALL be round-robin using a 1-bit priority pointer.
REQ-020 If only one request is high, that requester SHALL win.
REQ-021 If both requests are high, the requester named by the pointer SHALL win.
REQ-022 The winner's index, write_i, addr_i and wdata_i SHALL be registered on entry to SETUP.
REQ-023 The registered values SHALL drive pwrite, paddr and pwdata, unchanged through ACCESS.
REQ-024 SETUP SHALL drive psel=1 and penable=0 for exactly one cycle, then go to ACCESS.
REQ-025 ACCESS SHALL drive psel=1 and penable=1.
REQ-026 In ACCESS, while pready=0, the FSM SHALL stay in ACCESS (wait state).
REQ-027 In ACCESS, when pready=1, the FSM SHALL go to IDLE.
REQ-028 In the ACCESS cycle where pready=1, done_o[owner] SHALL be 1 combinationally and rdata_o SHALL equal prdata for reads (0 for writes).
REQ-029 On completion the pointer SHALL move to the other requester.
REQ-030 Minimum latency SHALL be 3 cycles: req_i seen in IDLE, then SETUP, then ACCESS with done.
REQ-031 Each added pready=0 cycle SHALL add one cycle of latency.
REQ-032 A requester SHALL drop req_i in the cycle after its done_o; IDLE samples it low and does not grant twice.
REQ-033 A request arriving or changing during SETUP/ACCESS SHALL NOT affect the transfer in flight.
REQ-034 Outside SETUP/ACCESS, psel and penable SHALL be 0; paddr, pwdata and pwrite SHALL hold their last values.

Reset
REQ-035 While presetn=0, the FSM SHALL be IDLE and the pointer SHALL be 0.
REQ-036 While presetn=0, psel, penable, pwrite, paddr, pwdata, done_o, err_o, rdata_o and busy_o SHALL be 0, and the wait counter SHALL be 0.
REQ-037 Reset asserted mid-transfer SHALL abort immediately with no done_o, and the next grant SHALL follow IDLE rules with pointer 0.

Configuration
REQ-038 The macro APB_MASTER_ARB_TIMEOUT_EN SHALL control the timeout feature.
REQ-039 With the macro defined, a wait counter SHALL clear on SETUP entry and increment for each ACCESS cycle with pready=0.
REQ-040 With the macro defined, when the counter equals TIMEOUT_CYCLES with pready still 0, the FSM SHALL go to IDLE and assert done_o[owner] and err_o[owner] for that cycle with rdata_o=0.
REQ-041 With the macro defined, a timeout SHALL rotate the pointer.
REQ-042 Without the macro, ACCESS SHALL wait indefinitely, err_o SHALL be constant 0, and no counter logic SHALL exist.

Verification
REQ-043 Single write: req_i=01, write=1, addr=4'h3, wdata=8'hA5, pready=1 -> SETUP then ACCESS with paddr=3, pwdata=A5; done_o=01 on cycle 3.
REQ-044 Single read with 2 wait states: req_i=10, read addr=4'h7, pready low 2 cycles, prdata=8'h5C -> done_o=10 on cycle 5 with rdata_o=5C.
REQ-045 Contention: both requests high from reset -> requester 0 served first, then requester 1, with one IDLE cycle between transfers.
REQ-046 Repeat contention after completion -> grant order alternates 0,1,0,1 over 4 transfers.
REQ-047 Reset mid-ACCESS: presetn low during a wait state -> psel, penable and done_o are 0 that cycle and the pointer returns to 0.
REQ-048 With APB_MASTER_ARB_TIMEOUT_EN and pready stuck at 0 -> after 15 wait cycles, done_o[owner]=1 and err_o[owner]=1 with rdata_o=0; without the macro, psel stays 1 indefinitely.

Source files
------------

// File: rtl/apb_master_arb_if.sv
// -----------------------------------------------------------------------------
// apb_master_arb_if
// APB bus bundle between the two-requester APB master and an APB slave.
//
// Signals:
//   psel, penable, pwrite  master -> slave  APB transfer controls
//   paddr  [ADDR_W]        master -> slave  address
//   pwdata [DATA_W]        master -> slave  write data
//   prdata [DATA_W]        slave  -> master read data
//   pready                 slave  -> master ready / wait-state control
//
// Handshake: a transfer occupies one SETUP cycle (psel=1, penable=0) followed
// by one or more ACCESS cycles (psel=1, penable=1). The transfer completes on
// the first ACCESS cycle in which the slave drives pready=1. prdata is only
// meaningful in that completing cycle of a read.
// -----------------------------------------------------------------------------
interface apb_master_arb_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/apb_master_arb.sv
// -----------------------------------------------------------------------------
// apb_master_arb
// APB master shared by two requesters with round-robin arbitration.
// A three-state FSM (IDLE -> SETUP -> ACCESS) runs one APB transfer at a time.
// In IDLE the winner is picked (single requester wins outright, on contention
// the 1-bit pointer decides); its direction, address and write data are
// captured and held on the bus until the next grant.
//
// Optional feature (macro APB_MASTER_ARB_TIMEOUT_EN): an ACCESS wait counter
// ends a transfer that has waited TIMEOUT_CYCLES cycles with pready still low,
// reporting done_o and err_o for the owner. Without the macro ACCESS waits
// forever and err_o is tied to 0.
//
// Ports:
//   pclk, presetn      clock, asynchronous active-low reset
//   req_i   [2]        per-requester request, held until that requester's done_o
//   write_i [2]        per-requester direction (1 = write)
//   addr_i  [2*ADDR_W] requester n uses [n*ADDR_W +: ADDR_W]
//   wdata_i [2*DATA_W] requester n uses [n*DATA_W +: DATA_W]
//   done_o  [2]        one-cycle completion pulse (combinational in ACCESS)
//   err_o   [2]        timeout error, valid with done_o
//   rdata_o [DATA_W]   read data, valid with done_o (0 for writes / timeouts)
//   busy_o             high in SETUP and ACCESS
//   state_o [2]        FSM state for observation (0 IDLE, 1 SETUP, 2 ACCESS)
//   apb                APB master modport
// -----------------------------------------------------------------------------
module apb_master_arb #(
    parameter int ADDR_W         = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic [1:0]            req_i,
    input  logic [1:0]            write_i,
    input  logic [2*ADDR_W-1:0]   addr_i,
    input  logic [2*DATA_W-1:0]   wdata_i,
    output logic [1:0]            done_o,
    output logic [1:0]            err_o,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  busy_o,
    output logic [1:0]            state_o,
    apb_master_arb_if.master      apb
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    // Elaboration-time sanity check on the wait limit.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("apb_master_arb: TIMEOUT_CYCLES must be at least 1");
    end

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              owner_q, owner_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;

    logic              grant;
    logic              psel_c;
    logic              penable_c;
    logic [1:0]        done_c;
    logic [DATA_W-1:0] rdata_c;

`ifdef APB_MASTER_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        err_c;
`endif

    // A lone request wins outright; the pointer only matters on contention.
    always_comb begin
        grant = ptr_q;
        if (req_i == 2'b01) begin
            grant = 1'b0;
        end else if (req_i == 2'b10) begin
            grant = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        psel_c    = 1'b0;
        penable_c = 1'b0;
        done_c    = 2'b00;
        rdata_c   = '0;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_c     = 2'b00;
`endif

        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    state_d  = S_SETUP;
                    owner_d  = grant;
                    pwrite_d = grant ? write_i[1] : write_i[0];
                    paddr_d  = grant ? addr_i[2*ADDR_W-1:ADDR_W] : addr_i[ADDR_W-1:0];
                    pwdata_d = grant ? wdata_i[2*DATA_W-1:DATA_W] : wdata_i[DATA_W-1:0];
`ifdef APB_MASTER_ARB_TIMEOUT_EN
                    cnt_d    = '0;
`endif
                end
            end

            S_SETUP: begin
                psel_c  = 1'b1;
                state_d = S_ACCESS;
            end

            S_ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
                if (apb.pready) begin
                    done_c  = owner_q ? 2'b10 : 2'b01;
                    rdata_c = pwrite_q ? '0 : apb.prdata;
                    state_d = S_IDLE;
                    ptr_d   = ~owner_q;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
                end else if (cnt_q == CNT_MAX) begin
                    // Slave never answered: give up, report an error, rotate.
                    done_c  = owner_q ? 2'b10 : 2'b01;
                    err_c   = owner_q ? 2'b10 : 2'b01;
                    state_d = S_IDLE;
                    ptr_d   = ~owner_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= S_IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
        end
    end

`ifdef APB_MASTER_ARB_TIMEOUT_EN
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign err_o = err_c;
`else
    assign err_o = 2'b00;
`endif

    assign apb.psel    = psel_c;
    assign apb.penable = penable_c;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;

    assign done_o  = done_c;
    assign rdata_o = rdata_c;
    assign busy_o  = (state_q != S_IDLE);
    assign state_o = state_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// -----------------------------------------------------------------------------
// tb_apb_master_arb
// Self-checking bench for apb_master_arb. Each transfer is predicted from the
// arbitration rules (lone requester wins, contention follows an alternating
// pointer that resets to 0) and the APB phase sequence (one IDLE cycle with the
// request visible, one SETUP cycle, then ACCESS cycles until pready). Define
// APB_MASTER_ARB_TIMEOUT_EN for both files to exercise the timeout build.
// -----------------------------------------------------------------------------
module tb_apb_master_arb;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 15;

    logic              pclk = 1'b0;
    logic              presetn;
    logic [1:0]        req_i;
    logic [1:0]        write_i;
    logic [2*AW-1:0]   addr_i;
    logic [2*DW-1:0]   wdata_i;
    logic [1:0]        done_o;
    logic [1:0]        err_o;
    logic [DW-1:0]     rdata_o;
    logic              busy_o;
    logic [1:0]        state_o;

    int checks = 0;
    int errors = 0;
    int model_ptr = 0;
    logic [1:0] exp_q[$];

    apb_master_arb_if #(.ADDR_W(AW), .DATA_W(DW)) apb ();

    apb_master_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .req_i   (req_i),
        .write_i (write_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .done_o  (done_o),
        .err_o   (err_o),
        .rdata_o (rdata_o),
        .busy_o  (busy_o),
        .state_o (state_o),
        .apb     (apb)
    );

    // ---------------- clock ----------------
    always #5 pclk = ~pclk;

    // ---------------- driver: one complete transfer ----------------
    // Entered just after an edge with the DUT in IDLE and requests visible.
    // Leaves just after the edge following done, winner's request dropped.
    task automatic one_transfer(input int waits, input bit timeout, input bit force_raise,
                                input logic [DW-1:0] rd, output int obs);
        int          w;
        bit          last;
        logic        e_wr;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic [1:0]  e_done;
        logic [1:0]  e_err;
        logic [DW-1:0] e_rd;
        obs    = -1;
        w      = (req_i == 2'b11) ? model_ptr : (req_i[1] ? 1 : 0);
        e_wr   = write_i[w];
        e_addr = addr_i[w*AW +: AW];
        e_wd   = wdata_i[w*DW +: DW];
        e_done = (w == 1) ? 2'b10 : 2'b01;

        #1;
        checks++;
        if ({apb.psel, apb.penable, busy_o, done_o, err_o, rdata_o} !== '0) begin
            errors++;
            $display("FAIL idle_outputs got psel=%0b pen=%0b busy=%0b done=%b err=%b rdata=%h exp all 0",
                     apb.psel, apb.penable, busy_o, done_o, err_o, rdata_o);
        end

        // SETUP: disturb requester inputs; the captured transfer must not move.
        @(posedge pclk); #1;
        addr_i  = (2*AW)'($urandom);
        wdata_i = (2*DW)'($urandom);
        write_i = 2'($urandom);
        if (force_raise) req_i[1-w] = 1'b1;
        #1;
        checks++;
        if ({apb.psel, apb.penable, busy_o, done_o, err_o, rdata_o} !== {3'b101, 4'b0000, {DW{1'b0}}}) begin
            errors++;
            $display("FAIL setup_ctrl got psel=%0b pen=%0b busy=%0b done=%b err=%b exp psel=1 pen=0 busy=1 done=00",
                     apb.psel, apb.penable, busy_o, done_o, err_o);
        end
        checks++;
        if ({apb.pwrite, apb.paddr, apb.pwdata} !== {e_wr, e_addr, e_wd}) begin
            errors++;
            $display("FAIL setup_bus got w=%0b a=%h d=%h exp w=%0b a=%h d=%h",
                     apb.pwrite, apb.paddr, apb.pwdata, e_wr, e_addr, e_wd);
        end

        // ACCESS: waits cycles of pready=0, then completion.
        for (int i = 0; i <= waits; i++) begin
            @(posedge pclk); #1;
            last        = (i == waits);
            apb.pready  = last && !timeout;
            apb.prdata  = last ? rd : DW'($urandom);
            #1;
            e_err = (last && timeout) ? e_done : 2'b00;
            e_rd  = (last && !timeout && !e_wr) ? rd : '0;
            checks++;
            if ({apb.psel, apb.penable, busy_o} !== 3'b111) begin
                errors++;
                $display("FAIL access_ctrl cyc=%0d got psel=%0b pen=%0b busy=%0b exp 1 1 1",
                         i, apb.psel, apb.penable, busy_o);
            end
            checks++;
            if ({done_o, err_o, rdata_o} !== {(last ? e_done : 2'b00), e_err, e_rd}) begin
                errors++;
                $display("FAIL access_resp cyc=%0d got done=%b err=%b rdata=%h exp done=%b err=%b rdata=%h",
                         i, done_o, err_o, rdata_o, (last ? e_done : 2'b00), e_err, e_rd);
            end
            checks++;
            if ({apb.pwrite, apb.paddr, apb.pwdata} !== {e_wr, e_addr, e_wd}) begin
                errors++;
                $display("FAIL access_bus cyc=%0d got a=%h d=%h exp a=%h d=%h",
                         i, apb.paddr, apb.pwdata, e_addr, e_wd);
            end
            if (last) obs = done_o[1] ? 1 : (done_o[0] ? 0 : -1);
        end

        // Back in IDLE: requester drops its request, bus values hold.
        @(posedge pclk); #1;
        req_i[w]   = 1'b0;
        apb.pready = 1'b0;
        model_ptr  = 1 - w;
        #1;
        checks++;
        if ({apb.psel, apb.penable, busy_o, done_o, err_o} !== '0) begin
            errors++;
            $display("FAIL post_idle got psel=%0b pen=%0b busy=%0b done=%b exp all 0",
                     apb.psel, apb.penable, busy_o, done_o);
        end
        checks++;
        if ({apb.pwrite, apb.paddr, apb.pwdata} !== {e_wr, e_addr, e_wd}) begin
            errors++;
            $display("FAIL post_hold got a=%h d=%h exp a=%h d=%h", apb.paddr, apb.pwdata, e_addr, e_wd);
        end
    endtask

    task automatic drain();
        int obs;
        for (int k = 0; k < 4 && req_i != 2'b00; k++) begin
            one_transfer(int'($urandom_range(0, 2)), 1'b0, 1'b0, DW'($urandom), obs);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        presetn    = 1'b0;
        req_i      = 2'b11;
        write_i    = 2'b11;
        addr_i     = 8'h21;
        wdata_i    = 16'hBEEF;
        apb.pready = 1'b0;
        apb.prdata = '0;
        repeat (2) @(posedge pclk);
        #1;
        checks++;
        if ({apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, done_o, err_o, rdata_o, busy_o, state_o} !== '0) begin
            errors++;
            $display("FAIL reset_values got psel=%0b pen=%0b pw=%0b a=%h d=%h done=%b err=%b rd=%h busy=%0b st=%0d exp all 0",
                     apb.psel, apb.penable, apb.pwrite, apb.paddr, apb.pwdata, done_o, err_o, rdata_o, busy_o, state_o);
        end
        presetn   = 1'b1;
        model_ptr = 0;
    endtask

    task automatic test_contention();
        int obs;
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        // Both requests have been high since reset.
        for (int k = 0; k < 2; k++) begin
            one_transfer(int'($urandom_range(0, 2)), 1'b0, 1'b0, DW'($urandom), obs);
            checks++;
            if (obs !== int'(exp_q[0])) begin
                errors++;
                $display("FAIL contention_order xfer=%0d got %0d exp %0d", k, obs, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        drain();
    endtask

    task automatic test_single_write();
        int obs;
        req_i   = 2'b01;
        write_i = 2'b01;
        addr_i  = {4'h0, 4'h3};
        wdata_i = {8'h00, 8'hA5};
        one_transfer(0, 1'b0, 1'b0, 8'h00, obs);
        drain();
    endtask

    task automatic test_single_read();
        int obs;
        req_i   = 2'b10;
        write_i = 2'b00;
        addr_i  = {4'h7, 4'h0};
        wdata_i = 16'h0000;
        one_transfer(2, 1'b0, 1'b0, 8'h5C, obs);
        checks++;
        if (obs !== 1) begin
            errors++;
            $display("FAIL read_owner got %0d exp 1", obs);
        end
        drain();
    endtask

    task automatic test_alternate();
        int obs;
        // Pointer is back at 0 after the preceding single transfers completed? Not
        // guaranteed, so force it: a lone requester-1 transfer leaves it at 0.
        req_i = 2'b10;
        one_transfer(0, 1'b0, 1'b0, DW'($urandom), obs);
        for (int k = 0; k < 4; k++) exp_q.push_back(2'(k % 2));
        req_i = 2'b11;
        for (int k = 0; k < 4; k++) begin
            one_transfer(int'($urandom_range(0, 3)), 1'b0, 1'b1, DW'($urandom), obs);
            checks++;
            if (obs !== int'(exp_q[0])) begin
                errors++;
                $display("FAIL alternate_order xfer=%0d got %0d exp %0d", k, obs, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        drain();
    endtask

    task automatic test_random();
        int obs;
        for (int k = 0; k < 20; k++) begin
            if (req_i == 2'b00) req_i = 2'($urandom_range(1, 3));
            write_i = 2'($urandom);
            addr_i  = (2*AW)'($urandom);
            wdata_i = (2*DW)'($urandom);
            one_transfer(int'($urandom_range(0, 3)), 1'b0, 1'($urandom_range(0, 1)), DW'($urandom), obs);
        end
        drain();
    endtask

    task automatic test_stuck_slave();
        int obs;
        req_i   = 2'b01;
        write_i = 2'b00;
        addr_i  = 8'h5A;
        wdata_i = 16'h1234;
`ifdef APB_MASTER_ARB_TIMEOUT_EN
        // 15 wait cycles counted, the 16th ACCESS cycle times out.
        one_transfer(TO, 1'b1, 1'b0, 8'hEE, obs);
`else
        // No timeout: ACCESS must still be holding after 40 wait cycles.
        one_transfer(40, 1'b0, 1'b0, 8'hEE, obs);
`endif
        drain();
    endtask

    task automatic test_reset_mid_access();
        int obs;
        // Leave the pointer at 1 so a reset back to 0 is observable.
        req_i   = 2'b01;
        write_i = 2'b00;
        one_transfer(0, 1'b0, 1'b0, DW'($urandom), obs);
        req_i   = 2'b11;
        addr_i  = {4'hC, 4'h4};
        wdata_i = {8'h99, 8'h11};
        @(posedge pclk); #1;       // SETUP
        @(posedge pclk); #1;       // ACCESS, wait state
        apb.pready = 1'b0;
        #1;
        presetn = 1'b0;
        #1;
        checks++;
        if ({apb.psel, apb.penable, done_o, err_o, busy_o, rdata_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_access got psel=%0b pen=%0b done=%b err=%b busy=%0b exp all 0",
                     apb.psel, apb.penable, done_o, err_o, busy_o);
        end
        @(posedge pclk); #1;
        presetn   = 1'b1;
        model_ptr = 0;
        addr_i    = {4'hC, 4'h4};
        wdata_i   = {8'h99, 8'h11};
        one_transfer(1, 1'b0, 1'b0, DW'($urandom), obs);
        checks++;
        if (obs !== 0) begin
            errors++;
            $display("FAIL reset_ptr_grant got %0d exp 0", obs);
        end
        drain();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_contention();
        test_single_write();
        test_single_read();
        test_alternate();
        test_random();
        test_stuck_slave();
        test_reset_mid_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
